// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: slew-limited servo PWM generator driven by a one-bit grip command.
// Optional SERVO_CMD_FILTER_EN: command must hold for CMD_FILTER_FRAMES frame boundaries before it is accepted.
module servo_pwm_driver #(
  parameter int PERIOD_CYCLES     = 1000000,
  parameter int MIN_PULSE         = 50000,
  parameter int MAX_PULSE         = 100000,
  parameter int STEP              = 500,
  parameter int CMD_FILTER_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_servo,
  output logic o_pwm,
  output logic o_at_open,
  output logic o_at_closed,
  output logic o_busy
);
  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam int SC = (STEP > MAX_PULSE - MIN_PULSE) ? MAX_PULSE - MIN_PULSE : STEP;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] PMIN = CW'(MIN_PULSE);
  localparam logic [CW-1:0] PMAX = CW'(MAX_PULSE);
  localparam logic [CW:0]   SW   = (CW+1)'(SC);
  typedef enum logic [1:0] {OPEN, CLOSING, CLOSED, OPENING} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, pos_q, pos_d, pos_up, pos_dn;
  logic [CW:0] up, dn;
  logic pwm_q, pwm_d, at_open_q, at_open_d, at_closed_q, at_closed_d, busy_q, busy_d;
  logic bnd, cmd;
  assign bnd = cnt_q == LAST;
  assign up = {1'b0, pos_q} + SW;
  assign dn = {1'b0, pos_q} - SW;
  // the step is pre-clamped to the travel range, so one spare bit holds both overflow and borrow
  assign pos_up = (up > {1'b0, PMAX}) ? PMAX : up[CW-1:0];
  assign pos_dn = (dn[CW] || dn < {1'b0, PMIN}) ? PMIN : dn[CW-1:0];
`ifdef SERVO_CMD_FILTER_EN
  localparam int FW = $clog2(CMD_FILTER_FRAMES + 1);
  logic [FW-1:0] stab_q, stab_d;
  logic last_q, last_d, filt_q, filt_d;
  always_comb begin
    stab_d = stab_q;
    last_d = last_q;
    filt_d = filt_q;
    if (bnd) begin
      last_d = i_servo;
      stab_d = (i_servo != last_q) ? FW'(1) : (stab_q == FW'(CMD_FILTER_FRAMES)) ? stab_q : stab_q + 1'b1;
      filt_d = (stab_d == FW'(CMD_FILTER_FRAMES)) ? i_servo : filt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
      last_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      stab_q <= stab_d;
      last_q <= last_d;
      filt_q <= filt_d;
    end
  end
  assign cmd = filt_d;
`else
  assign cmd = i_servo;
`endif
  always_comb begin
    cnt_d   = bnd ? '0 : cnt_q + 1'b1;
    pwm_d   = cnt_q < pos_q;
    pos_d   = pos_q;
    state_d = state_q;
    if (bnd) begin
      pos_d   = cmd ? pos_up : pos_dn;
      state_d = cmd ? ((pos_d == PMAX) ? CLOSED : CLOSING) : ((pos_d == PMIN) ? OPEN : OPENING);
    end
    at_open_d   = state_d == OPEN && pos_d == PMIN;
    at_closed_d = state_d == CLOSED && pos_d == PMAX;
    busy_d      = state_d == CLOSING || state_d == OPENING;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      pos_q       <= PMIN;
      state_q     <= OPEN;
      pwm_q       <= 1'b0;
      at_open_q   <= 1'b1;
      at_closed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      state_q     <= state_d;
      pwm_q       <= pwm_d;
      at_open_q   <= at_open_d;
      at_closed_q <= at_closed_d;
      busy_q      <= busy_d;
    end
  end
  assign o_pwm       = pwm_q;
  assign o_at_open   = at_open_q;
  assign o_at_closed = at_closed_q;
  assign o_busy      = busy_q;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    assert (MIN_PULSE < MAX_PULSE && MAX_PULSE < PERIOD_CYCLES && STEP >= 1)
      else $error("servo_pwm_driver: illegal pulse/period/step parameters");
`endif
endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: frame-level scoreboard for servo_pwm_driver with small bench parameters.
module tb_servo_pwm_driver;
  localparam int P = 100;
  logic clk = 1'b0, rst = 1'b1, i_servo = 1'b0;
  logic o_pwm, o_at_open, o_at_closed, o_busy;
  typedef struct packed {logic [31:0] w; logic ao; logic ac; logic bz;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;
  logic run;
  int tcnt, acc;
  always #5 clk = ~clk;
  servo_pwm_driver #(.PERIOD_CYCLES(P), .MIN_PULSE(10), .MAX_PULSE(20), .STEP(4), .CMD_FILTER_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .i_servo(i_servo), .o_pwm(o_pwm),
    .o_at_open(o_at_open), .o_at_closed(o_at_closed), .o_busy(o_busy)
  );
  // bench frame timer: tcnt==0 after the edge that closes a frame
  always @(posedge clk or posedge rst)
    if (rst) begin
      run  <= 1'b0;
      tcnt <= 0;
    end else begin
      run  <= 1'b1;
      tcnt <= (tcnt == P - 1) ? 0 : tcnt + 1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst) acc = 0;
    else begin
      acc += int'(o_pwm);
      if (run && tcnt == 0) begin
        if (q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          e = q.pop_front();
          chk("pulse_width", acc, e.w);
          chk("at_open", o_at_open, e.ao);
          chk("at_closed", o_at_closed, e.ac);
          chk("busy", o_busy, e.bz);
        end
        acc = 0;
      end
    end
  end
  task automatic wait_end();
    bit got = 0;
    for (int i = 0; i < 2 * P && !got; i++) begin
      @(negedge clk);
      got = run && tcnt == 0;
    end
    if (!got) chk("frame_timeout", 0, 1);
  endtask
  task automatic frame(input logic cmd, input int w, input logic ao, input logic ac, input logic bz);
    i_servo = cmd;
    q.push_back('{w, ao, ac, bz});
    wait_end();
  endtask
  task automatic glitch();
    i_servo = 1'b0;
    q.push_back('{10, 1'b1, 1'b0, 1'b0});
    repeat (40) @(negedge clk);
    i_servo = 1'b1;
    repeat (5) @(negedge clk);
    i_servo = 1'b0;
    chk("glitch_busy", o_busy, 0);
    wait_end();
  endtask
  task automatic reset_mid();
    repeat (5) @(negedge clk);
    chk("pwm_before_rst", o_pwm, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_pwm", o_pwm, 0);
    chk("rst_at_open", o_at_open, 1);
    chk("rst_at_closed", o_at_closed, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    #23;
    chk("init_pwm", o_pwm, 0);
    chk("init_at_open", o_at_open, 1);
    chk("init_at_closed", o_at_closed, 0);
    chk("init_busy", o_busy, 0);
    @(negedge clk);
    #1 rst = 1'b0;
`ifdef SERVO_CMD_FILTER_EN
    glitch();
    frame(1, 10, 1, 0, 0);
    frame(1, 10, 1, 0, 0);
    frame(0, 10, 1, 0, 0);
    frame(1, 10, 1, 0, 0);
    frame(1, 10, 1, 0, 0);
    frame(1, 10, 0, 0, 1);
    frame(1, 14, 0, 0, 1);
    reset_mid();
    frame(0, 10, 1, 0, 0);
`else
    frame(0, 10, 1, 0, 0);
    reset_mid();
    frame(0, 10, 1, 0, 0);
    frame(1, 10, 0, 0, 1);
    frame(1, 14, 0, 0, 1);
    frame(1, 18, 0, 1, 0);
    frame(1, 20, 0, 1, 0);
    frame(1, 20, 0, 1, 0);
    frame(0, 20, 0, 0, 1);
    frame(0, 16, 0, 0, 1);
    frame(0, 12, 1, 0, 0);
    frame(0, 10, 1, 0, 0);
    frame(1, 10, 0, 0, 1);
    frame(1, 14, 0, 0, 1);
    frame(0, 18, 0, 0, 1);
    frame(0, 14, 1, 0, 0);
    frame(0, 10, 1, 0, 0);
    glitch();
    frame(1, 10, 0, 0, 1);
    reset_mid();
    frame(0, 10, 1, 0, 0);
`endif
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
